display_mux: RTL and testbench

DISPLAY_MUX -- requirements
Module: display_mux

---
 rtl/display_mux_if.sv | 23 ++
 rtl/display_mux.sv | 102 ++++++++++
 tb/tb_display_mux.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/display_mux_if.sv
// display_mux_if: groups the scan, load and display signals of display_mux.
// master drives seq_sel/load/data_in/dp_in/blank_lz; slave drives a/cathodes/busy/ack.
interface display_mux_if;
    logic [10:0] seq_sel;
    logic        load;
    logic [31:0] data_in;
    logic [7:0]  dp_in;
    logic        blank_lz;
    logic [7:0]  a;
    logic [7:0]  cathodes;
    logic        busy;
    logic        ack;

    modport master (
        output seq_sel, load, data_in, dp_in, blank_lz,
        input  a, cathodes, busy, ack
    );

    modport slave (
        input  seq_sel, load, data_in, dp_in, blank_lz,
        output a, cathodes, busy, ack
    );
endinterface

// File: rtl/display_mux.sv
// display_mux: double-buffered 8-digit 7-segment driver with frame-synced update.
// Ports: clk, reset (async active-low), bus (slave: seq_sel/load/data in, a/cathodes/busy/ack out).
module display_mux (
    input  logic          clk,
    input  logic          reset,
    display_mux_if.slave  bus
);

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  dp;
        logic        blz;
    } disp_t;

    disp_t       shadow_q, shadow_d;
    disp_t       active_q, active_d;
    logic        busy_q, busy_d;
    logic        ack_q, ack_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  cath_q, cath_d;

    logic        sync;
    logic [2:0]  idx;
    logic [3:0]  nib;
    logic [7:0]  lz;
    logic        blank;
    logic [6:0]  seg;

    function automatic logic [6:0] enc(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            4'hF: s = 7'b0111000;
        endcase
        return s;
    endfunction

    always_comb begin
        idx  = bus.seq_sel[2:0];
        // Transfer happens on the last digit of the scan so a frame never mixes values.
        sync = busy_q && (idx == 3'b111);

        shadow_d = shadow_q;
        if (bus.load) begin
            shadow_d = '{data: bus.data_in, dp: bus.dp_in, blz: bus.blank_lz};
        end
        active_d = sync ? shadow_q : active_q;
        busy_d   = bus.load | (busy_q & ~sync);
        ack_d    = sync;

        // lz[k] = nibbles 7..k of the active value are all zero.
        lz[7] = (active_q.data[31:28] == 4'h0);
        for (int k = 6; k >= 0; k--) begin
            lz[k] = lz[k+1] && (active_q.data[4*k +: 4] == 4'h0);
        end

        nib   = active_q.data[{idx, 2'b00} +: 4];
        blank = active_q.blz && (idx != 3'd0) && lz[idx];
        seg   = blank ? 7'b1111111 : enc(nib);

        a_d    = bus.seq_sel[10:3];
        cath_d = {seg, ~active_q.dp[idx]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_q <= '0;
            active_q <= '0;
            busy_q   <= 1'b0;
            ack_q    <= 1'b0;
            a_q      <= 8'hFF;
            cath_q   <= 8'hFF;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            busy_q   <= busy_d;
            ack_q    <= ack_d;
            a_q      <= a_d;
            cath_q   <= cath_d;
        end
    end

    assign bus.a        = a_q;
    assign bus.cathodes = cath_q;
    assign bus.busy     = busy_q;
    assign bus.ack      = ack_q;

endmodule

// File: tb/tb_display_mux.sv
// tb_display_mux: scoreboard-checked bench for display_mux.
// Drives scan cycles, models shadow/active buffers, and compares every output cycle.
module tb_display_mux;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    display_mux_if bus ();

    display_mux dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] nib;
        logic [6:0] seg;
    } vec_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] cath;
        logic       busy;
        logic       ack;
    } exp_t;

    vec_t tbl [16];
    exp_t sb [$];

    int n_cmp = 0;
    int n_bad = 0;
    int ack_cnt = 0;

    logic [31:0] m_sh_data, m_act_data;
    logic [7:0]  m_sh_dp, m_act_dp;
    logic        m_sh_blz, m_act_blz;
    logic        m_busy;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        for (int i = 0; i < 16; i++) begin
            if (tbl[i].nib == n) return tbl[i].seg;
        end
        return 7'b1111111;
    endfunction

    function automatic logic [7:0] exp_cath(input int k);
        int         hi;
        logic [6:0] s;
        hi = 0;
        for (int j = 0; j < 8; j++) begin
            if (m_act_data[4*j +: 4] != 4'h0) hi = j;
        end
        if (m_act_blz && k > hi) s = 7'b1111111;
        else s = seg_of(m_act_data[4*k +: 4]);
        return {s, ~m_act_dp[k]};
    endfunction

    function automatic logic [7:0] an(input int i);
        logic [7:0] v;
        v = 8'h01 << i;
        return ~v;
    endfunction

    task automatic model_reset();
        m_sh_data = '0; m_sh_dp = '0; m_sh_blz = 1'b0;
        m_act_data = '0; m_act_dp = '0; m_act_blz = 1'b0;
        m_busy = 1'b0;
        sb.delete();
    endtask

    // One scan cycle: driven after a negedge, compared #1 after the posedge.
    task automatic cyc(input int idx, input logic [7:0] anode, input logic ld,
                       input logic [31:0] d, input logic [7:0] dp,
                       input logic blz);
        exp_t e, g;
        bit   sync;
        sync   = m_busy && (idx == 7);
        e.a    = anode;
        e.cath = exp_cath(idx);
        e.busy = ld || (m_busy && !sync);
        e.ack  = sync;
        sb.push_back(e);
        bus.seq_sel  = {anode, idx[2:0]};
        bus.load     = ld;
        bus.data_in  = d;
        bus.dp_in    = dp;
        bus.blank_lz = blz;
        @(posedge clk);
        if (sync) begin
            m_act_data = m_sh_data; m_act_dp = m_sh_dp; m_act_blz = m_sh_blz;
        end
        if (ld) begin
            m_sh_data = d; m_sh_dp = dp; m_sh_blz = blz;
        end
        m_busy = e.busy;
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            g = sb.pop_front();
            chk("a", bus.a, g.a);
            chk("cathodes", bus.cathodes, g.cath);
            chk("busy", bus.busy, g.busy);
            chk("ack", bus.ack, g.ack);
        end
        if (bus.ack) ack_cnt++;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic scan(input int from, input int to);
        for (int i = from; i <= to; i++) cyc(i, an(i), 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        tbl[0]  = '{4'h0, 7'b0000001}; tbl[1]  = '{4'h1, 7'b1001111};
        tbl[2]  = '{4'h2, 7'b0010010}; tbl[3]  = '{4'h3, 7'b0000110};
        tbl[4]  = '{4'h4, 7'b1001100}; tbl[5]  = '{4'h5, 7'b0100100};
        tbl[6]  = '{4'h6, 7'b0100000}; tbl[7]  = '{4'h7, 7'b0001111};
        tbl[8]  = '{4'h8, 7'b0000000}; tbl[9]  = '{4'h9, 7'b0000100};
        tbl[10] = '{4'hA, 7'b0001000}; tbl[11] = '{4'hB, 7'b1100000};
        tbl[12] = '{4'hC, 7'b0110001}; tbl[13] = '{4'hD, 7'b1000010};
        tbl[14] = '{4'hE, 7'b0110000}; tbl[15] = '{4'hF, 7'b0111000};

        model_reset();
        reset        = 1'b0;
        bus.seq_sel  = {8'hFE, 3'd0};
        bus.load     = 1'b0;
        bus.data_in  = '0;
        bus.dp_in    = '0;
        bus.blank_lz = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a", bus.a, 8'hFF);
        chk("rst_cath", bus.cathodes, 8'hFF);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_ack", bus.ack, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // First cycle after release: digit 0 of an all-zero active value.
        cyc(0, an(0), 1'b0, '0, '0, 1'b0);
        chk("first_a", bus.a, 8'hFE);
        chk("first_cath", bus.cathodes, 8'b00000011);
        scan(1, 2);

        // Load 0000_12AF with DP on digit 2 and leading-zero blanking.
        cyc(3, an(3), 1'b1, 32'h0000_12AF, 8'h04, 1'b1);
        chk("busy_after_load", bus.busy, 1'b1);
        scan(4, 7);
        chk("ack_after7", bus.ack, 1'b1);
        chk("busy_clear", bus.busy, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cyc(i, an(i), 1'b0, '0, '0, 1'b0);
            if (i >= 4) chk("lz_blank", bus.cathodes, 8'hFF);
            if (i == 3) chk("dig3_1", bus.cathodes, 8'b10011111);
            if (i == 2) chk("dig2_2dp", bus.cathodes, 8'b00100100);
            if (i == 1) chk("dig1_A", bus.cathodes, 8'b00010001);
            if (i == 0) chk("dig0_F", bus.cathodes, 8'b01110001);
        end

        // Table-driven: every hex glyph, eight per frame, no blanking.
        for (int f = 0; f < 2; f++) begin
            logic [31:0] d;
            for (int k = 0; k < 8; k++) d[4*k +: 4] = tbl[8*f + k].nib;
            cyc(0, an(0), 1'b1, d, 8'h00, 1'b0);
            scan(1, 7);
            for (int k = 0; k < 8; k++) begin
                cyc(k, an(k), 1'b0, '0, '0, 1'b0);
                chk("glyph", bus.cathodes, {tbl[8*f + k].seg, 1'b1});
            end
        end

        // Two loads in one frame: last wins, single ack.
        ack_cnt = 0;
        cyc(0, an(0), 1'b1, 32'h1111_1111, 8'h00, 1'b0);
        scan(1, 2);
        cyc(3, an(3), 1'b1, 32'h2222_2222, 8'h00, 1'b0);
        scan(4, 7);
        for (int k = 0; k < 8; k++) begin
            cyc(k, an(k), 1'b0, '0, '0, 1'b0);
            chk("last_wins", bus.cathodes, 8'b00100101);
        end
        chk("one_ack", ack_cnt, 1);

        // Load coincident with the transfer edge.
        cyc(2, an(2), 1'b1, 32'h3333_3333, 8'h00, 1'b0);
        scan(3, 6);
        cyc(7, an(7), 1'b1, 32'h4444_4444, 8'h00, 1'b0);
        chk("coinc_ack", bus.ack, 1'b1);
        chk("coinc_busy", bus.busy, 1'b1);
        for (int k = 0; k < 8; k++) begin
            cyc(k, an(k), 1'b0, '0, '0, 1'b0);
            chk("old_shadow", bus.cathodes, 8'b00001101);
        end
        chk("second_ack", bus.ack, 1'b1);
        cyc(0, an(0), 1'b0, '0, '0, 1'b0);
        chk("new_applied", bus.cathodes, 8'b10011001);

        // Invalid anode pattern passes straight through.
        cyc(5, 8'h5A, 1'b0, '0, '0, 1'b0);
        chk("bad_anode", bus.a, 8'h5A);

        // Value 0 with blanking: only digit 0 lit, DP still follows.
        cyc(6, an(6), 1'b1, 32'h0, 8'h81, 1'b1);
        scan(7, 7);
        for (int k = 0; k < 8; k++) begin
            cyc(k, an(k), 1'b0, '0, '0, 1'b0);
            if (k == 7) chk("blank_dp", bus.cathodes, 8'b11111110);
            if (k == 0) chk("zero_dp", bus.cathodes, 8'b00000010);
        end

        // Reset with an update pending mid-frame.
        cyc(1, an(1), 1'b1, 32'h89AB_CDEF, 8'hFF, 1'b1);
        scan(2, 4);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_a", bus.a, 8'hFF);
        chk("mid_rst_cath", bus.cathodes, 8'hFF);
        chk("mid_rst_busy", bus.busy, 1'b0);
        chk("mid_rst_ack", bus.ack, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 8; k++) begin
                cyc(k, an(k), 1'b0, '0, '0, 1'b0);
                chk("post_rst_zero", bus.cathodes, 8'b00000011);
            end
        end

        // Explicit all-zero value without blanking.
        cyc(0, an(0), 1'b1, 32'h0, 8'h00, 1'b0);
        scan(1, 7);
        for (int k = 0; k < 8; k++) begin
            cyc(k, an(k), 1'b0, '0, '0, 1'b0);
            chk("nolz_zero", bus.cathodes, 8'b00000011);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
